// File: rtl/stp_pkg.sv
// Shared types, constants and helpers for the serial-to-parallel deserialiser.
package stp_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } stp_state_e;

  localparam bit STP_MSB_FIRST = 1'b1;
  localparam bit STP_LSB_FIRST = 1'b0;

  function automatic int unsigned stp_cnt_w(input int unsigned data_w);
    return $clog2(data_w);
  endfunction

endpackage

// File: rtl/stp_deser_if.sv
// Control, serial input and word-output handshake bundle of stp_deser.
interface stp_deser_if #(
  parameter int unsigned DATA_W = 32
);
  logic              start;
  logic              cont;
  logic              abort;
  logic              in_bit;
  logic              in_valid;
  logic [DATA_W-1:0] data_o;
  logic              data_valid;
  logic              data_ready;
  logic              busy;
  logic              overrun;
  logic              clr_ovr;

  modport master (
    output start, cont, abort, in_bit, in_valid, data_ready, clr_ovr,
    input  data_o, data_valid, busy, overrun
  );

  modport slave (
    input  start, cont, abort, in_bit, in_valid, data_ready, clr_ovr,
    output data_o, data_valid, busy, overrun
  );
endinterface

// File: rtl/stp_hold_buf.sv
// Output holding register with valid/ready handshake; frees in the same cycle it is consumed.
module stp_hold_buf #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_ready,
  output logic [DATA_W-1:0] data_o,
  output logic              data_valid,
  output logic              free_c
);

  logic load_c;

  assign free_c = !data_valid || data_ready;
  assign load_c = load_req && free_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_o     <= '0;
      data_valid <= 1'b0;
    end else begin
      if (load_c) begin
        data_o     <= data_in;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/stp_deser.sv
// Serial-to-parallel deserialiser: FSM, bit counter, shifter and sticky overrun flag.
module stp_deser
  import stp_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter bit          MSB_FIRST = STP_MSB_FIRST
) (
  input logic        clk,
  input logic        rst_n,
  stp_deser_if.slave bus
);

  localparam int unsigned CNT_W = stp_cnt_w(DATA_W);

  stp_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] sreg_q;
  logic [DATA_W-1:0] sreg_nxt_c;
  logic              accept_c;
  logic              complete_c;
  logic              busy_c;
  logic              free_c;
  logic              overrun_q;

  // Shifter input path: the completing word includes the bit arriving this cycle.
  if (MSB_FIRST) begin : g_msb
    assign sreg_nxt_c = {sreg_q[DATA_W-2:0], bus.in_bit};
  end else begin : g_lsb
    assign sreg_nxt_c = {bus.in_bit, sreg_q[DATA_W-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT: begin
        if (bus.abort)                    state_d = IDLE;
        else if (complete_c && !bus.cont) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Abort masks bit acceptance, so it also wins over a completing bit.
  always_comb begin
    accept_c   = 1'b0;
    complete_c = 1'b0;
    busy_c     = 1'b0;
    if (state_q == SHIFT) begin
      busy_c     = 1'b1;
      accept_c   = bus.in_valid && !bus.abort;
      complete_c = accept_c && (cnt_q == CNT_W'(DATA_W - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      sreg_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (state_q == SHIFT && bus.abort) cnt_q <= '0;
      else if (accept_c)                 cnt_q <= complete_c ? '0 : cnt_q + CNT_W'(1);

      if (accept_c) sreg_q <= sreg_nxt_c;

      if (complete_c && !free_c) overrun_q <= 1'b1;
      else if (bus.clr_ovr)      overrun_q <= 1'b0;
    end
  end

  stp_hold_buf #(.DATA_W(DATA_W)) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_req  (complete_c),
    .data_in   (sreg_nxt_c),
    .data_ready(bus.data_ready),
    .data_o    (bus.data_o),
    .data_valid(bus.data_valid),
    .free_c    (free_c)
  );

  assign bus.busy    = busy_c;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_stp_deser.sv
// Directed bench for stp_deser: MSB-first and LSB-first 8-bit instances driven by the same stimulus.
module tb_stp_deser;

  logic clk;
  logic rst_n;
  logic start, cont, abort, in_bit, in_valid, data_ready, clr_ovr;

  int n_checks = 0;
  int n_errors = 0;

  stp_deser_if #(.DATA_W(8)) bus_m ();
  stp_deser_if #(.DATA_W(8)) bus_l ();

  assign bus_m.start = start;      assign bus_l.start = start;
  assign bus_m.cont = cont;        assign bus_l.cont = cont;
  assign bus_m.abort = abort;      assign bus_l.abort = abort;
  assign bus_m.in_bit = in_bit;    assign bus_l.in_bit = in_bit;
  assign bus_m.in_valid = in_valid; assign bus_l.in_valid = in_valid;
  assign bus_m.data_ready = data_ready; assign bus_l.data_ready = data_ready;
  assign bus_m.clr_ovr = clr_ovr;  assign bus_l.clr_ovr = clr_ovr;

  stp_deser #(.DATA_W(8), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst_n(rst_n), .bus(bus_m));
  stp_deser #(.DATA_W(8), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst_n(rst_n), .bus(bus_l));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    in_bit   = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Sends bits w[7-first] .. w[7-first-n+1], i.e. MSB-first order of w.
  task automatic send_bits(input logic [7:0] w, input int first, input int n);
    for (int i = first; i < first + n; i++) send_bit(w[7-i]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [7:0] w;
    rst_n = 1'b1; start = 0; cont = 0; abort = 0; in_bit = 0; in_valid = 0;
    data_ready = 0; clr_ovr = 0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_data_o",  32'(bus_m.data_o), 32'h0);
    check("rst_valid",   32'(bus_m.data_valid), 32'h0);
    check("rst_busy",    32'(bus_m.busy), 32'h0);
    check("rst_overrun", 32'(bus_m.overrun), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single word, consumer always ready
    data_ready = 1'b1;
    pulse_start();
    check("t1_busy_after_start", 32'(bus_m.busy), 32'h1);
    send_bits(8'hB2, 0, 7);
    check("t1_valid_before_last", 32'(bus_m.data_valid), 32'h0);
    check("t1_busy_before_last",  32'(bus_m.busy), 32'h1);
    send_bits(8'hB2, 7, 1);
    check("t1_valid",     32'(bus_m.data_valid), 32'h1);
    check("t1_data_msb",  32'(bus_m.data_o), 32'hB2);
    check("t1_data_lsb",  32'(bus_l.data_o), 32'h4D);
    check("t1_busy_done", 32'(bus_m.busy), 32'h0);
    tick();
    check("t1_valid_drop", 32'(bus_m.data_valid), 32'h0);

    // Same word with a gap after every bit
    pulse_start();
    w = 8'hB2;
    for (int i = 0; i < 15; i++) begin
      in_valid = (i % 2 == 0);
      in_bit   = w[7 - i/2];
      tick();
      in_valid = 1'b0;
      if (i % 2 == 1) check("t2_busy_gap", 32'(bus_m.busy), 32'h1);
    end
    check("t2_data_msb", 32'(bus_m.data_o), 32'hB2);
    check("t2_data_lsb", 32'(bus_l.data_o), 32'h4D);
    check("t2_valid",    32'(bus_m.data_valid), 32'h1);
    check("t2_busy_done", 32'(bus_m.busy), 32'h0);
    tick();

    // Back-pressure in continuous mode: words A5, 3C, 0F with consumer stalled
    data_ready = 1'b0;
    cont = 1'b1;
    pulse_start();
    send_bits(8'hA5, 0, 8);
    check("t3_valid_w1", 32'(bus_m.data_valid), 32'h1);
    check("t3_data_w1",  32'(bus_m.data_o), 32'hA5);
    check("t3_busy_cont", 32'(bus_m.busy), 32'h1);
    send_bits(8'h3C, 0, 7);
    check("t3_ovr_before16", 32'(bus_m.overrun), 32'h0);
    check("t3_data_held",    32'(bus_m.data_o), 32'hA5);
    send_bits(8'h3C, 7, 1);
    check("t3_ovr_at16",  32'(bus_m.overrun), 32'h1);
    check("t3_data_at16", 32'(bus_m.data_o), 32'hA5);
    check("t3_valid_at16", 32'(bus_m.data_valid), 32'h1);
    clr_ovr = 1'b1;
    send_bits(8'h0F, 0, 1);
    clr_ovr = 1'b0;
    check("t3_ovr_cleared", 32'(bus_m.overrun), 32'h0);
    send_bits(8'h0F, 1, 7);
    check("t3_ovr_at24",  32'(bus_m.overrun), 32'h1);
    check("t3_data_at24", 32'(bus_m.data_o), 32'hA5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t3_abort_idle", 32'(bus_m.busy), 32'h0);
    check("t3_abort_keeps_ovr", 32'(bus_m.overrun), 32'h1);
    data_ready = 1'b1;
    clr_ovr = 1'b1;
    tick();
    data_ready = 1'b0;
    clr_ovr = 1'b0;
    check("t3_drained", 32'(bus_m.data_valid), 32'h0);
    check("t3_ovr_clr", 32'(bus_m.overrun), 32'h0);

    // Release on the exact completion edge of word 2
    pulse_start();
    send_bits(8'h96, 0, 8);
    check("t4_data_w1", 32'(bus_m.data_o), 32'h96);
    send_bits(8'h69, 0, 7);
    data_ready = 1'b1;
    send_bits(8'h69, 7, 1);
    data_ready = 1'b0;
    check("t4_valid_stays", 32'(bus_m.data_valid), 32'h1);
    check("t4_data_w2",     32'(bus_m.data_o), 32'h69);
    check("t4_no_ovr",      32'(bus_m.overrun), 32'h0);
    abort = 1'b1;
    data_ready = 1'b1;
    tick();
    abort = 1'b0;
    data_ready = 1'b0;
    cont = 1'b0;
    check("t4_drained", 32'(bus_m.data_valid), 32'h0);

    // Abort on the cycle carrying the final bit
    pulse_start();
    send_bits(8'hE7, 0, 7);
    abort = 1'b1;
    send_bits(8'hE7, 7, 1);
    abort = 1'b0;
    check("t5_abort_busy",  32'(bus_m.busy), 32'h0);
    check("t5_abort_valid", 32'(bus_m.data_valid), 32'h0);
    check("t5_abort_ovr",   32'(bus_m.overrun), 32'h0);
    pulse_start();
    send_bits(8'hC3, 0, 8);
    check("t5_valid_after", 32'(bus_m.data_valid), 32'h1);
    check("t5_data_after",  32'(bus_m.data_o), 32'hC3);

    // Asynchronous reset mid-word, with a word still held
    pulse_start();
    send_bits(8'hFF, 0, 5);
    check("t6_busy_mid",  32'(bus_m.busy), 32'h1);
    check("t6_valid_mid", 32'(bus_m.data_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_data_m", 32'(bus_m.data_o), 32'h0);
    check("t6_rst_data_l", 32'(bus_l.data_o), 32'h0);
    check("t6_rst_valid",  32'(bus_m.data_valid), 32'h0);
    check("t6_rst_busy",   32'(bus_m.busy), 32'h0);
    check("t6_rst_ovr",    32'(bus_m.overrun), 32'h0);
    rst_n = 1'b1;
    tick();
    pulse_start();
    send_bits(8'h5A, 0, 8);
    check("t6_valid_after", 32'(bus_m.data_valid), 32'h1);
    check("t6_data_msb",    32'(bus_m.data_o), 32'h5A);
    check("t6_data_lsb",    32'(bus_l.data_o), 32'h5A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
